toggle_ctrl: RTL and testbench

Programmable controller that sequences a square-wave toggle output `q`. Software/upstream logic loads a half-period and a toggle count, then pulses `start`. The block toggles `q` every half-period until the count is exhausted, or runs continuously until `stop`. It provides a start/busy/done handshake so other blocks can schedule bursts of toggles on the shared signal.

---
 rtl/toggle_ctrl.sv | 88 ++++++++
 tb/tb_toggle_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/toggle_ctrl.sv
// rtl/toggle_ctrl.sv - programmable square-wave toggle sequencer with start/busy/done handshake
// Bursts of N toggles spaced half_period cycles apart, or continuous until stop.
module toggle_ctrl #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] half_period,
  input  logic [NUM_W-1:0] num_toggles,
  output logic             q,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] toggle_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] hp_latched;
  logic [NUM_W-1:0] num_latched;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      q           <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      toggle_cnt  <= '0;
      period_cnt  <= '0;
      hp_latched  <= '0;
      num_latched <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          // A zero half-period would never toggle, so such requests are dropped.
          if (start && (half_period != '0)) begin
            hp_latched  <= half_period;
            num_latched <= num_toggles;
            q           <= 1'b0;
            toggle_cnt  <= '0;
            period_cnt  <= '0;
            busy        <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            q     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (period_cnt == hp_latched - CNT_W'(1)) begin
            q          <= ~q;
            period_cnt <= '0;
            toggle_cnt <= toggle_cnt + NUM_W'(1);
            // num_latched of zero means continuous; the count simply wraps.
            if ((num_latched != '0) && (toggle_cnt + NUM_W'(1) == num_latched)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end else begin
            period_cnt <= period_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_ctrl.sv
// tb/tb_toggle_ctrl.sv - directed self-checking bench for toggle_ctrl
module tb_toggle_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [15:0] half_period;
  logic [7:0]  num_toggles;
  logic        q;
  logic        busy;
  logic        done;
  logic [7:0]  toggle_cnt;

  int errors = 0;
  int checks = 0;

  toggle_ctrl #(.CNT_W(16), .NUM_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .half_period (half_period),
    .num_toggles (num_toggles),
    .q           (q),
    .busy        (busy),
    .done        (done),
    .toggle_cnt  (toggle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on falling edges.
  task automatic tick();
    @(negedge clk);
  endtask

  // hp=3, N=4 burst: q low 3 cycles, high 3, low 3, high 3, then done with q=0.
  task automatic burst_hp3_n4(input string tag);
    half_period = 16'd3;
    num_toggles = 8'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk({tag, "_q"}, q, ((i / 3) % 2));
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_done_lo"}, done, 0);
      tick();
    end
    chk({tag, "_end_q"}, q, 0);
    chk({tag, "_end_busy"}, busy, 0);
    chk({tag, "_end_done"}, done, 1);
    chk({tag, "_end_cnt"}, toggle_cnt, 4);
    tick();
    chk({tag, "_idle_done"}, done, 0);
    chk({tag, "_idle_q"}, q, 0);
    chk({tag, "_idle_cnt"}, toggle_cnt, 4);
    tick();
    chk({tag, "_idle2_busy"}, busy, 0);
    chk({tag, "_idle2_q"}, q, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    half_period = '0;
    num_toggles = '0;

    // 1: reset values and quiet idle
    tick();
    tick();
    chk("rst_q", q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", toggle_cnt, 0);
    rst = 1'b0;
    tick();
    tick();
    tick();
    chk("idle_q", q, 0);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_cnt", toggle_cnt, 0);

    // stop in IDLE ignored
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("idle_stop_busy", busy, 0);
    chk("idle_stop_done", done, 0);

    // 2: finite burst
    burst_hp3_n4("b34");

    // 3: odd count, start during DONE ignored
    half_period = 16'd2;
    num_toggles = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("odd_q", q, ((i / 2) % 2));
      chk("odd_busy", busy, 1);
      tick();
    end
    chk("odd_end_q", q, 1);
    chk("odd_end_done", done, 1);
    chk("odd_end_busy", busy, 0);
    chk("odd_end_cnt", toggle_cnt, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_start_busy", busy, 0);
    chk("done_start_done", done, 0);
    chk("done_start_q", q, 1);
    chk("done_start_cnt", toggle_cnt, 3);
    tick();
    chk("done_start_busy2", busy, 0);
    chk("odd_hold_q", q, 1);

    // 5: zero half-period ignored
    half_period = 16'd0;
    num_toggles = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("hp0_busy", busy, 0);
    chk("hp0_q", q, 1);
    tick();
    chk("hp0_busy2", busy, 0);
    chk("hp0_cnt", toggle_cnt, 3);

    // 4: continuous mode, stop on a toggle edge; mid-run input changes ignored
    half_period = 16'd1;
    num_toggles = 8'd0;
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("cont_start_busy", busy, 1);
    chk("cont_start_q", q, 0);
    chk("cont_start_cnt", toggle_cnt, 0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("cont_q", q, (k % 2));
      chk("cont_cnt", toggle_cnt, k);
      chk("cont_busy", busy, 1);
      if (k == 3) begin
        start = 1'b1;
        half_period = 16'd7;
        num_toggles = 8'd2;
      end
      if (k == 5) start = 1'b0;
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_q", q, 0);
    chk("stop_done", done, 1);
    chk("stop_busy", busy, 0);
    chk("stop_cnt", toggle_cnt, 10);
    tick();
    chk("stop_done_lo", done, 0);
    chk("stop_idle_cnt", toggle_cnt, 10);

    // 6: reset mid-run after the 2nd toggle
    half_period = 16'd5;
    num_toggles = 8'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("mid_pre_cnt", toggle_cnt, 2);
    chk("mid_pre_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_q", q, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_cnt", toggle_cnt, 0);
    tick();
    chk("mid_rst_done2", done, 0);
    rst = 1'b0;
    tick();
    chk("mid_rel_done", done, 0);
    chk("mid_rel_busy", busy, 0);
    burst_hp3_n4("rerun");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
